// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, geometry and address decode for the read cache
// Purpose: state encoding, cache geometry, address-field positions and the
//          address decode helper used by cache_controller.
// Ports:   none (package).
package cache_pkg;

  localparam int SETS    = 64;
  localparam int TAG_W   = 10;
  localparam int INDEX_W = $clog2(SETS);
  localparam logic [31:0] BASE_ADDR = 32'd1024;

  // Field positions inside the base-relative address; bits [1:0] are the byte
  // offset and are never looked at.
  localparam int WORD_SEL_BIT = 2;
  localparam int INDEX_LSB    = 3;
  localparam int TAG_LSB      = INDEX_LSB + INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic               word_sel;
  } addr_fields_t;

  // The subtraction wraps at 32 bits, so addresses below the base simply alias.
  function automatic addr_fields_t decode_addr(input logic [31:0] address);
    logic [31:0]  m;
    addr_fields_t f;
    m          = address - BASE_ADDR;
    f.word_sel = 1'(m >> WORD_SEL_BIT);
    f.index    = INDEX_W'(m >> INDEX_LSB);
    f.tag      = TAG_W'(m >> TAG_LSB);
    return f;
  endfunction

  function automatic logic [31:0] select_word(input logic [63:0] block, input logic word_sel);
    return word_sel ? block[63:32] : block[31:0];
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// rtl/cache_way_array.sv - one way of the cache: valid, tag and data arrays
// Purpose: storage for a single way, combinational read, synchronous write.
// Ports:   clk, rst (sync, active-low; clears valid bits only)
//          rd_index -> rd_valid, rd_tag, rd_data   combinational lookup
//          fill_en, wr_index, fill_tag, fill_data   write a line and mark it valid
//          inv_en, wr_index                        clear the valid bit of a line
module cache_way_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [63:0]        rd_data,
  input  logic               fill_en,
  input  logic               inv_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [63:0]        fill_data
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [63:0]      data_q [SETS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[wr_index] <= 1'b1;
    end else if (inv_en) begin
      valid_q[wr_index] <= 1'b0;
    end
  end

  // Tag and data need no reset: they are only ever read behind a valid bit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[wr_index]  <= fill_tag;
      data_q[wr_index] <= fill_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - two-way set-associative read cache, write-through store path
// Purpose: serves load hits with zero wait, fills 64-bit blocks on load misses,
//          forwards stores straight to SRAM (no allocate, hit line invalidated).
// Ports:   clk, rst (sync, active-low)
//          address, wdata, MEM_R_EN, MEM_W_EN   request from MEM stage
//          rdata, ready                         load data / pipeline freeze (0 = freeze)
//          sram_address, sram_wdata             pass-through to SRAM controller
//          sram_read, sram_write                SRAM enables (Moore, registered)
//          sram_rdata, sram_ready               block and done strobe from SRAM controller
module cache_controller
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read,
  output logic        sram_write,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  state_t       state;
  addr_fields_t f;
  logic [SETS-1:0] lru_q;

  logic               valid0, valid1;
  logic [TAG_W-1:0]   tag0, tag1;
  logic [63:0]        data0, data1;
  logic               hit0, hit1, hit;
  logic [63:0]        hit_data;
  logic               victim;
  logic               fill0, fill1, inv0, inv1;

  assign f            = decode_addr(address);
  assign sram_address = address;
  assign sram_wdata   = wdata;

  // Way 0 takes precedence if both ways ever hold the same tag.
  assign hit0     = valid0 && (tag0 == f.tag);
  assign hit1     = valid1 && (tag1 == f.tag) && !hit0;
  assign hit      = hit0 || hit1;
  assign hit_data = hit0 ? data0 : data1;

  // Fill an empty way before evicting; only with both ways full does LRU decide.
  always_comb begin
    if (!valid0) begin
      victim = 1'b0;
    end else if (!valid1) begin
      victim = 1'b1;
    end else begin
      victim = lru_q[f.index];
    end
  end

  always_comb begin
    ready = 1'b1;
    rdata = '0;
    fill0 = 1'b0;
    fill1 = 1'b0;
    inv0  = 1'b0;
    inv1  = 1'b0;
    case (state)
      IDLE: begin
        if (MEM_W_EN) begin
          ready = 1'b0;
          inv0  = hit0;
          inv1  = hit1;
        end else if (MEM_R_EN) begin
          ready = hit;
          if (hit) begin
            rdata = select_word(hit_data, f.word_sel);
          end
        end
      end
      READ_MISS: begin
        ready = sram_ready;
        if (sram_ready) begin
          rdata = select_word(sram_rdata, f.word_sel);
          fill0 = !victim;
          fill1 = victim;
        end
      end
      WRITE: begin
        ready = sram_ready;
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end

  // The enables are registered alongside the state so they track it exactly
  // and drop on the edge after sram_ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lru_q      <= '0;
      sram_read  <= 1'b0;
      sram_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (MEM_W_EN) begin
            state      <= WRITE;
            sram_write <= 1'b1;
          end else if (MEM_R_EN) begin
            if (hit) begin
              lru_q[f.index] <= hit0;
            end else begin
              state     <= READ_MISS;
              sram_read <= 1'b1;
            end
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            lru_q[f.index] <= !victim;
            state          <= IDLE;
            sram_read      <= 1'b0;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            state      <= IDLE;
            sram_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          sram_read  <= 1'b0;
          sram_write <= 1'b0;
        end
      endcase
    end
  end

  cache_way_array u_way0 (
    .clk      (clk),
    .rst      (rst),
    .rd_index (f.index),
    .rd_valid (valid0),
    .rd_tag   (tag0),
    .rd_data  (data0),
    .fill_en  (fill0),
    .inv_en   (inv0),
    .wr_index (f.index),
    .fill_tag (f.tag),
    .fill_data(sram_rdata)
  );

  cache_way_array u_way1 (
    .clk      (clk),
    .rst      (rst),
    .rd_index (f.index),
    .rd_valid (valid1),
    .rd_tag   (tag1),
    .rd_data  (data1),
    .fill_en  (fill1),
    .inv_en   (inv1),
    .wr_index (f.index),
    .fill_tag (f.tag),
    .fill_data(sram_rdata)
  );

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed vector bench for cache_controller
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read;
  logic        sram_write;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .wdata       (wdata),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .rdata       (rdata),
    .ready       (ready),
    .sram_address(sram_address),
    .sram_wdata  (sram_wdata),
    .sram_read   (sram_read),
    .sram_write  (sram_write),
    .sram_rdata  (sram_rdata),
    .sram_ready  (sram_ready)
  );

  // SRAM controller stand-in: done strobe on the 5th cycle an enable is high.
  int unsigned sram_cnt;
  always @(posedge clk) begin
    if (!rst || !(sram_read || sram_write)) sram_cnt <= 0;
    else sram_cnt <= sram_cnt + 1;
  end
  assign sram_ready = (sram_read || sram_write) && (sram_cnt == 4);

  // Block contents: word0 = 2*blk+1, word1 = 2*blk+2, blk = (addr-1024)>>3.
  function automatic logic [63:0] block_of(input logic [31:0] a);
    logic [31:0] b;
    b = (a - 32'd1024) >> 3;
    return {b * 32'd2 + 32'd2, b * 32'd2 + 32'd1};
  endfunction
  assign sram_rdata = block_of(sram_address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_access(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d,
                            output int cyc, output logic [31:0] rd, output int rdc, output int wrc,
                            output logic [31:0] sa, output logic [31:0] swd, output logic tmo);
    bit done;
    @(posedge clk); #1;
    address = a; MEM_R_EN = r; MEM_W_EN = w; wdata = d;
    cyc = 0; rdc = 0; wrc = 0; rd = '0; sa = '0; swd = '0; tmo = 1'b0; done = 1'b0;
    while (!done) begin
      #1;
      cyc++;
      if (sram_read) rdc++;
      if (sram_write) wrc++;
      if (ready) begin
        done = 1'b1; rd = rdata; sa = sram_address; swd = sram_wdata;
      end else if (cyc >= 40) begin
        done = 1'b1; tmo = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        r;
    logic        w;
    logic [31:0] d;
    int          exp_cyc;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d,
                              input int c, input logic cr, input logic [31:0] er, input int nr, input int nw);
    vec_t v;
    v.addr = a; v.r = r; v.w = w; v.d = d; v.exp_cyc = c;
    v.chk_rdata = cr; v.exp_rdata = er; v.exp_rd = nr; v.exp_wr = nw;
    return v;
  endfunction

  task automatic apply(input string tag, input vec_t v);
    int cyc, rdc, wrc;
    logic [31:0] rd, sa, swd;
    logic tmo;
    run_access(v.addr, v.r, v.w, v.d, cyc, rd, rdc, wrc, sa, swd, tmo);
    check({tag, "_timeout"}, 32'(tmo), 32'd0);
    check({tag, "_cycles"}, cyc, v.exp_cyc);
    check({tag, "_sram_read_cycles"}, rdc, v.exp_rd);
    check({tag, "_sram_write_cycles"}, wrc, v.exp_wr);
    check({tag, "_sram_address"}, sa, v.addr);
    if (v.chk_rdata) check({tag, "_rdata"}, rd, v.exp_rdata);
    if (v.w) check({tag, "_sram_wdata"}, swd, v.d);
  endtask

  vec_t vecs[20];

  initial begin
    vecs[0]  = mk(32'd1024, 1, 0, 0, 6, 1, 32'd1,   5, 0);  // cold miss, fill way0
    vecs[1]  = mk(32'd1028, 1, 0, 0, 1, 1, 32'd2,   0, 0);  // hit, upper word
    vecs[2]  = mk(32'd1536, 1, 0, 0, 6, 1, 32'd129, 5, 0);  // index 0 tag 1 -> way1
    vecs[3]  = mk(32'd2048, 1, 0, 0, 6, 1, 32'd257, 5, 0);  // tag 2 evicts way0 (tag 0)
    vecs[4]  = mk(32'd1536, 1, 0, 0, 1, 1, 32'd129, 0, 0);  // still hits
    vecs[5]  = mk(32'd1024, 1, 0, 0, 6, 1, 32'd1,   5, 0);  // evicted earlier, misses
    vecs[6]  = mk(32'd1536, 1, 0, 0, 1, 1, 32'd129, 0, 0);  // 1536 survived
    vecs[7]  = mk(32'd2048, 1, 0, 0, 6, 1, 32'd257, 5, 0);  // LRU picks way0 (1024)
    vecs[8]  = mk(32'd1024, 1, 0, 0, 6, 1, 32'd1,   5, 0);  // LRU picks way1 (1536)
    vecs[9]  = mk(32'd1024, 1, 0, 0, 1, 1, 32'd1,   0, 0);  // hit before store
    vecs[10] = mk(32'd1024, 0, 1, 32'hDEAD_BEEF, 6, 0, 0, 0, 5);
    vecs[11] = mk(32'd1024, 1, 0, 0, 6, 1, 32'd1,   5, 0);  // invalidated -> refill
    vecs[12] = mk(32'd2048, 1, 0, 0, 1, 1, 32'd257, 0, 0);  // other way untouched
    vecs[13] = mk(32'd1088, 0, 1, 32'h0000_1234, 6, 0, 0, 0, 5);  // no allocate
    vecs[14] = mk(32'd1088, 1, 0, 0, 6, 1, 32'd17,  5, 0);
    vecs[15] = mk(32'd1092, 1, 0, 0, 1, 1, 32'd18,  0, 0);
    vecs[16] = mk(32'd1024, 1, 1, 32'h1234_5678, 6, 0, 0, 0, 5);  // store wins
    vecs[17] = mk(32'd1024, 1, 0, 0, 6, 1, 32'd1,   5, 0);  // invalidated by store
    vecs[18] = mk(32'd1031, 1, 0, 0, 1, 1, 32'd2,   0, 0);  // byte offset ignored
    vecs[19] = mk(32'd1027, 1, 0, 0, 1, 1, 32'd1,   0, 0);

    rst = 1'b0; address = '0; wdata = '0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_rdata", rdata, 32'd0);
    check("reset_sram_read", 32'(sram_read), 32'd0);
    check("reset_sram_write", 32'(sram_write), 32'd0);

    for (int i = 0; i < 20; i++) begin
      apply($sformatf("v%0d", i), vecs[i]);
    end

    // Reset in the middle of a read miss abandons it and empties the cache.
    @(posedge clk); #1;
    address = 32'd1536; MEM_R_EN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_in_miss_sram_read", 32'(sram_read), 32'd1);
    check("midrst_in_miss_ready", 32'(ready), 32'd0);
    rst = 1'b0; MEM_R_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_sram_read", 32'(sram_read), 32'd0);
    check("midrst_sram_write", 32'(sram_write), 32'd0);
    apply("post_rst_1024", mk(32'd1024, 1, 0, 0, 6, 1, 32'd1,   5, 0));
    apply("post_rst_2048", mk(32'd2048, 1, 0, 0, 6, 1, 32'd257, 5, 0));
    apply("post_rst_hit",  mk(32'd1028, 1, 0, 0, 1, 1, 32'd2,   0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
